// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: sequences C = A x B for DIM x DIM matrices through one shared
// MAC. Operands are read from the A/B RAMs in dot-product order (k fastest,
// then j, then i), streamed to the MAC with sof framing, and each MAC result
// is written row-major into the C RAM.
// Optional build macro MMC_TIMEOUT_EN: drain watchdog raising a sticky err.
`timescale 1ns/1ps
module mat_mul_ctrl #(
  parameter int DIM     = 5,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+DIM-1,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  a_addr,
  output logic [ADDR_W-1:0]  b_addr,
  output logic               rd_en,
  input  logic [WIDTH-1:0]   a_rdata,
  input  logic [WIDTH-1:0]   b_rdata,
  output logic [WIDTH-1:0]   mac_a,
  output logic [WIDTH-1:0]   mac_b,
  output logic               mac_sof,
  input  logic [M_WIDTH-1:0] mac_c,
  input  logic               mac_valid,
  output logic               c_we,
  output logic [ADDR_W-1:0]  c_addr,
  output logic [M_WIDTH-1:0] c_wdata,
  output logic               err
);

  localparam int CW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TOTAL = DIM * DIM;
  localparam int RW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] KMAX     = CW'(DIM - 1);
  localparam logic [RW-1:0] RCNT_END = RW'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      i_q, i_d;
  logic [CW-1:0]      j_q, j_d;
  logic [CW-1:0]      k_q, k_d;
  logic [RW-1:0]      rcnt_q, rcnt_d;
  logic               sof_q, sof_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  caddr_q, caddr_d;
  logic [M_WIDTH-1:0] cdata_q, cdata_d;

  logic start_acc;
  logic last_issue;
  logic capture;
  logic all_written;
  logic timeout_hit;

  assign start_acc   = (state_q == S_IDLE) && start;
  assign last_issue  = (state_q == S_ISSUE) && (i_q == KMAX) && (j_q == KMAX) && (k_q == KMAX);
  assign all_written = (rcnt_q == RCNT_END);
  // Results are accepted only while a job is running and not all slots are filled.
  assign capture     = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && mac_valid && !all_written;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Reaching DONE on the registered count means the final
  // C write is already on the bus, so done lands the cycle after it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)       state_d = S_ISSUE;
      S_ISSUE: if (last_issue)  state_d = S_DRAIN;
      S_DRAIN: begin
        if (all_written)      state_d = S_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    rd_en = (state_q == S_ISSUE);
  end

  // Loop counters: k innermost, then j, then i; all wrap to 0 after the last read.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (start_acc) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (state_q == S_ISSUE) begin
      if (k_q == KMAX) begin
        k_d = '0;
        if (j_q == KMAX) begin
          j_d = '0;
          i_d = (i_q == KMAX) ? '0 : i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
      end else begin
        k_d = k_q + CW'(1);
      end
    end
  end

  // Result capture and MAC framing next-state values.
  always_comb begin
    sof_d   = (state_q == S_ISSUE);
    we_d    = capture;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    rcnt_d  = rcnt_q;
    if (start_acc) begin
      rcnt_d = '0;
    end else if (capture) begin
      caddr_d = ADDR_W'(rcnt_q);
      cdata_d = mac_c;
      rcnt_d  = rcnt_q + RW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      rcnt_q  <= '0;
      sof_q   <= 1'b0;
      we_q    <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      rcnt_q  <= rcnt_d;
      sof_q   <= sof_d;
      we_q    <= we_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  // Read addresses: A walks row i along k, B walks column j along k.
  always_comb begin
    a_addr = ADDR_W'(i_q) * ADDR_W'(DIM) + ADDR_W'(k_q);
    b_addr = ADDR_W'(k_q) * ADDR_W'(DIM) + ADDR_W'(j_q);
  end

  assign mac_a   = a_rdata;
  assign mac_b   = b_rdata;
  assign mac_sof = sof_q;
  assign c_we    = we_q;
  assign c_addr  = caddr_q;
  assign c_wdata = cdata_q;

`ifdef MMC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;

  assign timeout_hit = (state_q == S_DRAIN) && !all_written && !mac_valid &&
                       (tcnt_q == TW'(TIMEOUT - 1));

  // Watchdog: counts DRAIN cycles since the last MAC result; err is sticky until a new start.
  always_comb begin
    tcnt_d = ((state_q != S_DRAIN) || mac_valid) ? '0 : tcnt_q + TW'(1);
    err_d  = start_acc ? 1'b0 : (err_q | timeout_hit);
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: doc/mat_mul_ctrl.md
Name: mat_mul_ctrl

Overview:
Sequencer that computes C = A x B for square DIM x DIM matrices using one shared MAC datapath. It reads operands from the A and B RAMs in dot-product order and streams them into the MAC with sof framing. It collects each MAC result and writes it row-major into C RAM, then signals completion. It sits between the host start/done interface, the three matrix RAMs and the MAC instance.

Parameters:
DIM, 5, matrix dimension; equals the MAC's N (dot-product length).
WIDTH, 16, operand width; equals the MAC's WIDTH.
M_WIDTH, 2*WIDTH+DIM-1, result width; equals the MAC's M_WIDTH.
ADDR_W, 5, RAM address width; must satisfy 2^ADDR_W >= DIM*DIM.
TIMEOUT, 64, drain watchdog limit in cycles; used only with MMC_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to begin; sampled in IDLE only.
busy  out  1  high from the cycle after start is accepted until DONE exits.
done  out  1  one-cycle pulse when all DIM*DIM results are written.
a_addr  out  ADDR_W  A RAM read address.
b_addr  out  ADDR_W  B RAM read address.
rd_en  out  1  read enable for A and B RAMs.
a_rdata  in  WIDTH  A RAM data; valid 1 cycle after rd_en.
b_rdata  in  WIDTH  B RAM data; valid 1 cycle after rd_en.
mac_a  out  WIDTH  MAC operand A; combinational pass-through of a_rdata.
mac_b  out  WIDTH  MAC operand B; combinational pass-through of b_rdata.
mac_sof  out  1  MAC framing strobe, registered.
mac_c  in  M_WIDTH  MAC result.
mac_valid  in  1  MAC result strobe.
c_we  out  1  C RAM write enable, registered.
c_addr  out  ADDR_W  C RAM write address, registered.
c_wdata  out  M_WIDTH  C RAM write data, registered.
err  out  1  watchdog error flag; tied 0 when the feature is off.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0. busy, done, rd_en, mac_sof, c_we and err are 0. a_addr, b_addr, c_addr and c_wdata are 0.
- Counters: i (row), j (column), k (dot index), each 0..DIM-1. rcnt counts results, 0..DIM*DIM.
- IDLE: start=1 -> ISSUE; clear i, j, k, rcnt and err. mac_valid is ignored in IDLE.
- ISSUE: one read per cycle. rd_en=1, a_addr=i*DIM+k, b_addr=k*DIM+j.
  - k increments each cycle. On k=DIM-1, k wraps to 0 and j increments.
  - On j=DIM-1 at that wrap, j wraps to 0 and i increments.
  - After issuing i=j=k=DIM-1, go to DRAIN with rd_en=0.
  - ISSUE lasts exactly DIM^3 cycles; there are no stalls.
- mac_sof = rd_en delayed 1 cycle, so it aligns with RAM data. It stays high continuously for DIM^3 cycles, giving back-to-back dot products, then drops.
- Result capture, in ISSUE or DRAIN: on mac_valid=1, the next cycle has c_we=1, c_addr=rcnt and c_wdata=mac_c, and rcnt increments.
  - When rcnt=DIM*DIM, further mac_valid pulses are ignored.
- DRAIN: rd_en=0. When rcnt reaches DIM*DIM and no write is pending -> DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, -> IDLE.
- start while busy is ignored. start in the DONE cycle is ignored.
- Reset mid-operation aborts immediately with no done pulse. C RAM contents are undefined; the next start restarts from (0,0,0).
- Address arithmetic is unsigned, with width ADDR_W. The controller does no data arithmetic.

Optional Feature:
MMC_TIMEOUT_EN
- Defined: a counter in DRAIN clears on every mac_valid. If it reaches TIMEOUT without a mac_valid, err=1 (sticky until the next accepted start) and the block goes to IDLE with no done pulse.
- Undefined: no counter; err is tied 0; DRAIN waits indefinitely.

Test Plan:
1. Identity: DIM=5, A=I, B[r][c]=r*5+c, start -> C RAM equals B; done one cycle after the 25th c_we; ISSUE=125 cycles.
2. All-ones A and B -> all 25 C words = 5; c_addr sequence 0..24 in order.
3. A=B=all 16'hFFFF -> every C word = 36'h4FFF60005, with no truncation.
4. start pulsed at ISSUE cycle 10 and in the DONE cycle -> ignored; exactly one done pulse and 25 writes.
5. rst_n low at ISSUE cycle 40 -> all outputs 0 within the same cycle (async); a subsequent start gives a correct full result.
6. With MMC_TIMEOUT_EN and the MAC model dropping its last mac_valid -> err=1 exactly 64 cycles after the 24th valid, no done, back to IDLE. Without the macro, the block stays busy.
